// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B4 signal bundle: the master modport drives the request side, the slave modport answers.
// Tag fields share one width so every arbiter port can be the same interface type.
interface wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic [ADDR_W-1:0]   ADR;
    logic [TAG_W-1:0]    TGA;
    logic [2:0]          CTI;
    logic [1:0]          BTE;
    logic [DATA_W-1:0]   DAT_W;
    logic [TAG_W-1:0]    TGD_W;
    logic                CYC;
    logic [TAG_W-1:0]    TGC;
    logic [DATA_W/8-1:0] SEL;
    logic                STB;
    logic                WE;
    logic                ACK;
    logic                ERR;
    logic [DATA_W-1:0]   DAT_R;
    logic [TAG_W-1:0]    TGD_R;

    modport master (
        output ADR, TGA, CTI, BTE, DAT_W, TGD_W, CYC, TGC, SEL, STB, WE,
        input  ACK, ERR, DAT_R, TGD_R
    );

    modport slave (
        input  ADR, TGA, CTI, BTE, DAT_W, TGD_W, CYC, TGC, SEL, STB, WE,
        output ACK, ERR, DAT_R, TGD_R
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N upstream masters share one downstream port, grant held for a whole CYC.
// Optional stall watchdog with DRAIN state is compiled in with `define WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_TAG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    wb_if.slave                          m [N_MASTERS],
    wb_if.master                         s,
    output logic [$clog2(N_MASTERS)-1:0] gnt,
    output logic                         gnt_valid
);
    localparam int GW = $clog2(N_MASTERS);
    localparam int SW = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        DRAIN   = 2'd2,
`endif
        GRANTED = 2'd1
    } state_t;

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_rr_arbiter: unsupported parameter set");
    end

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   pick, cand;
    logic            found;
    logic            s_cyc, s_stb, s_we, own_ack, own_err;

    logic [WB_ADDR_WIDTH-1:0] adr_v  [N_MASTERS];
    logic [WB_TAG_WIDTH-1:0]  tga_v  [N_MASTERS];
    logic [2:0]               cti_v  [N_MASTERS];
    logic [1:0]               bte_v  [N_MASTERS];
    logic [WB_DATA_WIDTH-1:0] datw_v [N_MASTERS];
    logic [WB_TAG_WIDTH-1:0]  tgdw_v [N_MASTERS];
    logic [WB_TAG_WIDTH-1:0]  tgc_v  [N_MASTERS];
    logic [SW-1:0]            sel_v  [N_MASTERS];
    logic [N_MASTERS-1:0]     cyc_v, stb_v, we_v;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Interface arrays only allow constant indices, so flatten them for the grant mux.
    for (genvar k = 0; k < N_MASTERS; k++) begin : g_port
        assign adr_v[k]   = m[k].ADR;
        assign tga_v[k]   = m[k].TGA;
        assign cti_v[k]   = m[k].CTI;
        assign bte_v[k]   = m[k].BTE;
        assign datw_v[k]  = m[k].DAT_W;
        assign tgdw_v[k]  = m[k].TGD_W;
        assign tgc_v[k]   = m[k].TGC;
        assign sel_v[k]   = m[k].SEL;
        assign cyc_v[k]   = m[k].CYC;
        assign stb_v[k]   = m[k].STB;
        assign we_v[k]    = m[k].WE;
        assign m[k].ACK   = own_ack && (gnt_q == GW'(k));
        assign m[k].ERR   = own_err && (gnt_q == GW'(k));
        assign m[k].DAT_R = s.DAT_R;
        assign m[k].TGD_R = s.TGD_R;
    end

    assign s.ADR   = adr_v[gnt_q];
    assign s.TGA   = tga_v[gnt_q];
    assign s.CTI   = cti_v[gnt_q];
    assign s.BTE   = bte_v[gnt_q];
    assign s.DAT_W = datw_v[gnt_q];
    assign s.TGD_W = tgdw_v[gnt_q];
    assign s.TGC   = tgc_v[gnt_q];
    assign s.SEL   = sel_v[gnt_q];
    assign s.CYC   = s_cyc;
    assign s.STB   = s_stb;
    assign s.WE    = s_we;

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANTED);

    // First requester strictly after the previous owner, wrapping.
    always_comb begin
        pick  = gnt_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = GW'((int'(last_q) + i) % N_MASTERS);
            if (!found && cyc_v[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        own_ack = 1'b0;
        own_err = 1'b0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANTED;
                    gnt_d   = pick;
                    last_d  = pick;
                end
            end
            GRANTED: begin
                s_cyc   = cyc_v[gnt_q];
                s_stb   = stb_v[gnt_q];
                s_we    = we_v[gnt_q];
                own_ack = s.ACK;
                own_err = s.ERR;
                if (!cyc_v[gnt_q]) begin
                    state_d = IDLE;
                end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
                else if (s.ACK || s.ERR) begin
                    cnt_d = '0;
                end else if (stb_v[gnt_q]) begin
                    // The count includes the current stalled cycle, so the error lands on stall number TIMEOUT_CYCLES.
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        s_cyc   = 1'b0;
                        s_stb   = 1'b0;
                        own_ack = 1'b0;
                        own_err = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
            DRAIN: begin
                own_err = stb_v[gnt_q];
                if (!cyc_v[gnt_q]) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (reset) begin
            s_cyc   = 1'b0;
            s_stb   = 1'b0;
            s_we    = 1'b0;
            own_ack = 1'b0;
            own_err = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= GW'(N_MASTERS - 1);
            gnt_q   <= '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with three masters and a scripted downstream slave.
// Inputs change 1 time unit after the rising edge; outputs are compared 2 units later.
module tb_wb_rr_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_adr   [3];
    logic [2:0]  m_cti   [3];
    logic [31:0] m_dat_r [3];
    logic        s_ack, s_err;
    logic [31:0] s_dat;
    logic [1:0]  gnt;
    logic        gnt_valid;
    int          n_cmp = 0;
    int          n_bad = 0;

    wb_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) mif [3] ();
    wb_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(4)) sif ();

    for (genvar k = 0; k < 3; k++) begin : g_m
        assign mif[k].ADR   = m_adr[k];
        assign mif[k].TGA   = 4'(k);
        assign mif[k].CTI   = m_cti[k];
        assign mif[k].BTE   = 2'b00;
        assign mif[k].DAT_W = 32'(k);
        assign mif[k].TGD_W = '0;
        assign mif[k].CYC   = m_cyc[k];
        assign mif[k].TGC   = '0;
        assign mif[k].SEL   = 4'hF;
        assign mif[k].STB   = m_stb[k];
        assign mif[k].WE    = m_we[k];
        assign m_ack[k]     = mif[k].ACK;
        assign m_err[k]     = mif[k].ERR;
        assign m_dat_r[k]   = mif[k].DAT_R;
    end

    assign sif.ACK   = s_ack;
    assign sif.ERR   = s_err;
    assign sif.DAT_R = s_dat;
    assign sif.TGD_R = '0;

    wb_rr_arbiter #(
        .N_MASTERS(3), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
        .WB_TAG_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .m(mif), .s(sif),
        .gnt(gnt), .gnt_valid(gnt_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
        for (int i = 0; i < 3; i++) begin
            m_adr[i] = '0;
            m_cti[i] = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) tick();
        reset = 1'b0;
        #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_valid: got %b want 0", gnt_valid); end
        n_cmp++; if (gnt !== 2'd0) begin n_bad++; $display("FAIL rst_gnt: got %0d want 0", gnt); end
        n_cmp++; if ({sif.CYC, sif.STB, sif.WE} !== 3'b000) begin n_bad++; $display("FAIL rst_s_ctl: got %b want 000", {sif.CYC, sif.STB, sif.WE}); end
        n_cmp++; if ({m_ack, m_err} !== 6'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b want 000000", {m_ack, m_err}); end
    endtask

    task automatic test_single_read();
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100;
        #2;
        n_cmp++; if (sif.CYC !== 1'b0) begin n_bad++; $display("FAIL rd_latency_cyc: got %b want 0", sif.CYC); end
        tick(); #2;
        n_cmp++; if (sif.CYC !== 1'b1) begin n_bad++; $display("FAIL rd_s_cyc: got %b want 1", sif.CYC); end
        n_cmp++; if (gnt !== 2'd0 || gnt_valid !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %0d/%b want 0/1", gnt, gnt_valid); end
        n_cmp++; if (sif.ADR !== 32'h100) begin n_bad++; $display("FAIL rd_s_adr: got %h want 00000100", sif.ADR); end
        tick(); #2;
        n_cmp++; if (m_ack[1:0] !== 2'b00) begin n_bad++; $display("FAIL rd_wait_ack: got %b want 00", m_ack[1:0]); end
        tick();
        s_ack = 1'b1; s_dat = 32'hCAFE0001;
        #2;
        n_cmp++; if (m_ack[0] !== 1'b1) begin n_bad++; $display("FAIL rd_m0_ack: got %b want 1", m_ack[0]); end
        n_cmp++; if (m_dat_r[0] !== 32'hCAFE0001) begin n_bad++; $display("FAIL rd_m0_dat: got %h want cafe0001", m_dat_r[0]); end
        n_cmp++; if (m_ack[1] !== 1'b0) begin n_bad++; $display("FAIL rd_m1_ack: got %b want 0", m_ack[1]); end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        n_cmp++; if (sif.CYC !== 1'b0 || gnt_valid !== 1'b1) begin n_bad++; $display("FAIL rd_release: got cyc=%b gv=%b want 0/1", sif.CYC, gnt_valid); end
        tick(); #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got %b want 0", gnt_valid); end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        m_cyc = 3'b011; m_stb = 3'b011; m_adr[0] = 32'h10; m_adr[1] = 32'h20;
        #2;
        n_cmp++; if (sif.CYC !== 1'b0) begin n_bad++; $display("FAIL sim_idle_cyc: got %b want 0", sif.CYC); end
        tick();
        s_ack = 1'b1;
        #2;
        n_cmp++; if (gnt !== 2'd0 || sif.ADR !== 32'h10) begin n_bad++; $display("FAIL sim_first: got gnt=%0d adr=%h want 0/00000010", gnt, sif.ADR); end
        n_cmp++; if (m_ack[1:0] !== 2'b01) begin n_bad++; $display("FAIL sim_first_ack: got %b want 01", m_ack[1:0]); end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        n_cmp++; if (sif.CYC !== 1'b0) begin n_bad++; $display("FAIL sim_drop: got %b want 0", sif.CYC); end
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL sim_dead: got %b want 0", gnt_valid); end
        tick();
        s_ack = 1'b1;
        #2;
        n_cmp++; if (gnt !== 2'd1 || sif.ADR !== 32'h20) begin n_bad++; $display("FAIL sim_second: got gnt=%0d adr=%h want 1/00000020", gnt, sif.ADR); end
        n_cmp++; if (m_ack[1:0] !== 2'b10) begin n_bad++; $display("FAIL sim_second_ack: got %b want 10", m_ack[1:0]); end
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        tick(); #2;
        n_cmp++; if (gnt !== 2'd0 || gnt_valid !== 1'b1) begin n_bad++; $display("FAIL sim_third: got %0d/%b want 0/1", gnt, gnt_valid); end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] exp_cti;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h30;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h200; m_cti[1] = 3'b010;
        #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL bst_idle: got %b want 0", gnt_valid); end
        for (int b = 0; b < 4; b++) begin
            tick();
            exp_cti = (b == 3) ? 3'b111 : 3'b010;
            m_adr[1] = 32'h200 + 32'(4 * b);
            m_cti[1] = exp_cti;
            s_ack = 1'b1;
            #2;
            n_cmp++; if (gnt !== 2'd1) begin n_bad++; $display("FAIL bst_gnt_beat%0d: got %0d want 1", b, gnt); end
            n_cmp++; if (m_ack[1:0] !== 2'b10) begin n_bad++; $display("FAIL bst_ack_beat%0d: got %b want 10", b, m_ack[1:0]); end
            n_cmp++; if (sif.CTI !== exp_cti) begin n_bad++; $display("FAIL bst_cti_beat%0d: got %b want %b", b, sif.CTI, exp_cti); end
        end
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = 3'b000;
        #2;
        n_cmp++; if (m_ack[0] !== 1'b0 || sif.CYC !== 1'b0) begin n_bad++; $display("FAIL bst_end: got ack0=%b cyc=%b want 0/0", m_ack[0], sif.CYC); end
        tick(); #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL bst_dead: got %b want 0", gnt_valid); end
        tick();
        s_ack = 1'b1;
        #2;
        n_cmp++; if (gnt !== 2'd0 || m_ack[0] !== 1'b1) begin n_bad++; $display("FAIL bst_m0_served: got gnt=%0d ack=%b want 0/1", gnt, m_ack[0]); end
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        tick(); #2;
        n_cmp++; if (sif.CYC !== 1'b1 || gnt !== 2'd0) begin n_bad++; $display("FAIL rm_active: got cyc=%b gnt=%0d want 1/0", sif.CYC, gnt); end
        tick();
        reset = 1'b1; s_ack = 1'b1;
        #2;
        n_cmp++; if ({sif.CYC, sif.STB} !== 2'b00) begin n_bad++; $display("FAIL rm_forced: got %b want 00", {sif.CYC, sif.STB}); end
        n_cmp++; if (m_ack[0] !== 1'b0) begin n_bad++; $display("FAIL rm_ack: got %b want 0", m_ack[0]); end
        tick();
        reset = 1'b0; s_ack = 1'b0; m_we = '0;
        m_cyc = 3'b011; m_stb = 3'b011;
        #2;
        n_cmp++; if (gnt_valid !== 1'b0 || gnt !== 2'd0) begin n_bad++; $display("FAIL rm_after: got gv=%b gnt=%0d want 0/0", gnt_valid, gnt); end
        tick(); #2;
        n_cmp++; if (gnt !== 2'd0 || gnt_valid !== 1'b1) begin n_bad++; $display("FAIL rm_last_reset: got %0d/%b want 0/1", gnt, gnt_valid); end
        tick();
        m_cyc = '0; m_stb = '0;
        tick();
    endtask

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_err;
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) begin m_cyc[1] = 1'b1; m_stb[1] = 1'b1; end
            #2;
            exp_err = (c == 8);
            n_cmp++; if (m_err[0] !== exp_err || sif.CYC !== !exp_err) begin n_bad++; $display("FAIL to_stall%0d: got err=%b cyc=%b want %b/%b", c, m_err[0], sif.CYC, exp_err, !exp_err); end
        end
        tick(); #2;
        n_cmp++; if (gnt_valid !== 1'b0 || m_err[0] !== 1'b1 || sif.CYC !== 1'b0) begin n_bad++; $display("FAIL to_drain: got gv=%b err=%b cyc=%b want 0/1/0", gnt_valid, m_err[0], sif.CYC); end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        n_cmp++; if (m_err[0] !== 1'b0) begin n_bad++; $display("FAIL to_drain_err: got %b want 0", m_err[0]); end
        tick(); #2;
        n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL to_idle: got %b want 0", gnt_valid); end
        tick(); #2;
        n_cmp++; if (gnt !== 2'd1 || sif.CYC !== 1'b1) begin n_bad++; $display("FAIL to_next: got gnt=%0d cyc=%b want 1/1", gnt, sif.CYC); end
        tick();
        m_cyc = '0; m_stb = '0;
        tick();
    endtask
`endif

    task automatic test_rotation();
        logic [2:0] acked;
        int         seq [8];
        int         ng;
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        m_cyc = 3'b111; m_stb = 3'b111;
        acked = '0;
        ng = 0;
        for (int i = 0; i < 8; i++) seq[i] = -1;
        // Each master drops CYC for exactly one cycle after its ACK, then requests again.
        for (int c = 0; c < 21; c++) begin
            tick();
            s_ack = 1'b0;
            m_cyc = ~acked; m_stb = ~acked;
            #1;
            s_ack = sif.CYC & sif.STB;
            #1;
            acked = m_ack;
            if (gnt_valid && s_ack) begin
                if (ng < 8) seq[ng] = int'(gnt);
                ng++;
            end
        end
        s_ack = 1'b0;
        n_cmp++; if (ng < 6) begin n_bad++; $display("FAIL rot_count: got %0d want >=6", ng); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (seq[i] !== i % 3) begin n_bad++; $display("FAIL rot_seq%0d: got %0d want %0d", i, seq[i], i % 3); end
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst();
        test_reset_mid();
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        test_rotation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one downstream slave port between `N_MASTERS` upstream masters. It sits between bus masters (CPU, DMA) and a shared interconnect segment or address adapter. It locks the grant for the full duration of the owner's `CYC`, including bursts. It routes request signals downstream and `ACK`/`ERR`/`DAT_R`/`TGD_R` back to the owning master only.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of upstream masters, range 2..8.
- `WB_ADDR_WIDTH`, default 32: address width of all ports.
- `WB_DATA_WIDTH`, default 32: data width of all ports. `SEL` width is `WB_DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 256: watchdog limit. Used only with `WB_RR_ARBITER_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `m[N_MASTERS]`  wb_if.slave  —  upstream master ports.
- `s`  wb_if.master  —  shared downstream port.
- `gnt`  out  $clog2(N_MASTERS)  index of the current owner.
- `gnt_valid`  out  1  high while state is GRANTED.

## Operation
- States: IDLE, GRANTED, DRAIN. DRAIN exists only with `WB_RR_ARBITER_TIMEOUT_EN`.
- Registered `last` holds the index of the most recent owner.
- IDLE:
  - `s.CYC`, `s.STB` and `s.WE` are 0.
  - If any `m[k].CYC`=1, pick the first requester searching from `last+1` upward, wrapping modulo `N_MASTERS`.
  - At the next edge: `gnt`←k, `last`←k, state→GRANTED.
- GRANTED:
  - `s.{ADR,TGA,CTI,BTE,DAT_W,TGD_W,CYC,TGC,SEL,STB,WE}` = `m[gnt]` equivalents, combinational.
  - `m[gnt].{ACK,ERR,DAT_R,TGD_R}` = `s` equivalents, combinational.
  - When `m[gnt].CYC`=0, state→IDLE at the next edge.
- Non-owners:
  - `ACK`=0 and `ERR`=0 at all times.
  - `DAT_R` and `TGD_R` are broadcast from `s` and are don't-care.
- Requests from non-owners are ignored until re-arbitration. There is no preemption.
- Reset values:
  - State IDLE; `last`=`N_MASTERS-1`, so master 0 wins first; `gnt`=0; `gnt_valid`=0.
  - `s.CYC`, `s.STB`, `s.WE` = 0; all `m[k].ACK` and `m[k].ERR` = 0.
- While `reset`=1, `s.CYC`, `s.STB` and all master `ACK`/`ERR` are forced to 0 combinationally. A transaction interrupted by reset is abandoned.

## Timing
- Grant latency: `m[k].CYC` rising in cycle t (state IDLE) → `s.CYC`=1 in cycle t+1.
- Release: owner drops `CYC` in cycle t → `s.CYC`=0 in t (pass-through) → IDLE in t+1 → next owner drives `s` in t+2. There is one dead cycle between owners.
- Simultaneous requests in IDLE: strict rotation after `last`. Example with `last`=0 and masters 0, 1, 2 all requesting: master 1 is granted.
- A single requester may be re-granted back-to-back, with the one dead cycle between grants.
- `ACK`/`ERR` path: zero added latency, purely combinational through the grant mux.

## Configuration
- `WB_RR_ARBITER_TIMEOUT_EN` defined:
  - A counter increments each GRANTED cycle with `s.STB`=1 and `ACK`=`ERR`=0.
  - The counter clears on `ACK`, on `ERR`, or on leaving GRANTED.
  - When the count equals `TIMEOUT_CYCLES`, in that same cycle:
    - `m[gnt].ERR`=1;
    - `s.CYC`=0 and `s.STB`=0;
    - state→DRAIN at the next edge.
  - DRAIN:
    - `s.CYC`=0.
    - `m[gnt].ERR` = `m[gnt].STB`.
    - `m[gnt].ACK`=0.
    - State→IDLE once `m[gnt].CYC`=0.
  - `gnt_valid`=0 in DRAIN.
- Not defined: no counter and no DRAIN state. A stalled slave holds the grant indefinitely.

## Test plan
- Single master 0 read, slave ACKs after 2 wait states:
  - required: `s.CYC` rises 1 cycle after `m[0].CYC`;
  - `m[0].DAT_R` equals slave data in the ACK cycle;
  - `m[1].ACK` stays 0 throughout.
- Masters 0 and 1 request in the same cycle out of reset:
  - required: master 0 granted first;
  - master 1 granted 2 cycles after master 0 drops `CYC`;
  - then master 0 is served again.
- Master 1 runs a 4-beat incrementing burst (`CTI`=3'b010, last beat 3'b111) while master 0 requests:
  - required: `gnt` stays 1 for all 4 ACKs;
  - master 0 receives no `ACK` until granted afterwards.
- Reset is asserted during master 0's active transfer:
  - required: `s.CYC`=0 in the same cycle;
  - after reset, `gnt_valid`=0 and `last`=`N_MASTERS-1`.
- With `WB_RR_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, slave never ACKs:
  - required: `m[gnt].ERR` pulses in the 8th stalled cycle with `s.CYC`=0;
  - arbiter enters DRAIN, then returns to IDLE after the master drops `CYC`;
  - the next requester is granted.
- With `N_MASTERS`=3 and all three requesting continuously with single-beat cycles:
  - required: grant sequence is 0, 1, 2, 0, 1, 2, …
